imem_loader: RTL and testbench

Byte-stream program loader that drives the write port (port A) of the instruction memory. It accepts framed bytes over a valid/ready stream, typically from the UART receiver, and packs them into byte-masked 32-bit writes. It validates the address range and an 8-bit checksum, and reports the outcome with status pulses. It sits between the serial front end and `imem`, alongside the CPU's read-only fetch port B.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_word_packer.sv | 86 ++++++++
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader_pkg : shared FSM encoding and frame field sizes for imem_loader
// Rev 1.0
// ----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         ADDR_FIELD_BYTES  = 4;
    localparam int         LEN_FIELD_BYTES   = 4;
    localparam int         HDR_CNT_W         = 2;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_word_packer : steers bytes into lanes, accumulates the write mask and
//                    issues one registered imem port-A write per flush
// Rev 1.0
// ----------------------------------------------------------------------------
module imem_word_packer #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [1:0]            lane,
    input  logic [7:0]            data_in,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] waddr,
    output logic                  imem_ena,
    output logic [3:0]            imem_wea,
    output logic [ADDR_WIDTH-1:0] imem_addra,
    output logic [31:0]           imem_dina
);

    logic [31:0]           acc_q, acc_d, acc_next;
    logic [3:0]            mask_q, mask_d, mask_next;
    logic                  ena_q, ena_d;
    logic [3:0]            wea_q, wea_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d;
    logic [31:0]           dina_q, dina_d;

    always_comb begin
        acc_next  = acc_q;
        mask_next = mask_q;
        for (int i = 0; i < 4; i++) begin
            if (lane == 2'(i)) begin
                acc_next[8*i +: 8] = data_in;
                mask_next[i]       = 1'b1;
            end
        end

        acc_d   = acc_q;
        mask_d  = mask_q;
        ena_d   = 1'b0;
        wea_d   = 4'd0;
        addra_d = addra_q;
        dina_d  = dina_q;
        if (byte_valid) begin
            acc_d  = acc_next;
            mask_d = mask_next;
            if (flush) begin
                // Accumulator only ever holds bytes of the current frame, so
                // unwritten lanes of the flushed word are already zero.
                ena_d   = 1'b1;
                wea_d   = mask_next;
                addra_d = waddr;
                dina_d  = acc_next;
                acc_d   = 32'd0;
                mask_d  = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= 32'd0;
            mask_q  <= 4'd0;
            ena_q   <= 1'b0;
            wea_q   <= 4'd0;
            addra_q <= '0;
            dina_q  <= 32'd0;
        end else begin
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            ena_q   <= ena_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
        end
    end

    assign imem_ena   = ena_q;
    assign imem_wea   = wea_q;
    assign imem_addra = addra_q;
    assign imem_dina  = dina_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader : framed byte-stream loader driving imem port A with range and
//               checksum validation and one-cycle status pulses
// Rev 1.0
// ----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 14,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_ena,
    output logic [3:0]            imem_wea,
    output logic [ADDR_WIDTH-1:0] imem_addra,
    output logic [31:0]           imem_dina,
    output logic                  busy,
    output logic                  done,
    output logic                  csum_err,
    output logic                  range_err
);

    localparam int               BA_W       = ADDR_WIDTH + 2;
    localparam logic [32:0]      BYTE_SPACE = 33'd1 << BA_W;
    localparam logic [HDR_CNT_W-1:0] ADDR_LAST = HDR_CNT_W'(ADDR_FIELD_BYTES - 1);
    localparam logic [HDR_CNT_W-1:0] LEN_LAST  = HDR_CNT_W'(LEN_FIELD_BYTES - 1);

    state_t                 state_q, state_d;
    logic [HDR_CNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            len_q, len_d;
    logic [BA_W-1:0]        baddr_q, baddr_d;
    logic [31:0]            rem_q, rem_d;
    logic [7:0]             csum_q, csum_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   csum_err_q, csum_err_d;
    logic                   range_err_q, range_err_d;

    logic                   xfer;
    logic [31:0]            len_full;
    logic [32:0]            frame_end;
    logic                   data_xfer;

    assign xfer      = in_valid && ready_q;
    assign len_full  = {in_data, len_q[31:8]};
    assign frame_end = {1'b0, addr_q} + {1'b0, len_full};
    assign data_xfer = xfer && (state_q == ST_DATA);

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        baddr_d     = baddr_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        csum_err_d  = 1'b0;
        range_err_d = 1'b0;

        if (xfer) begin
            case (state_q)
                ST_SYNC: begin
                    if (in_data == SYNC_BYTE) begin
                        busy_d    = 1'b1;
                        csum_d    = 8'd0;
                        hdr_cnt_d = '0;
                        state_d   = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    addr_d    = {in_data, addr_q[31:8]};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == ADDR_LAST) begin
                        hdr_cnt_d = '0;
                        state_d   = ST_LEN;
                    end
                end
                ST_LEN: begin
                    len_d     = len_full;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == LEN_LAST) begin
                        hdr_cnt_d = '0;
                        baddr_d   = addr_q[BA_W-1:0];
                        rem_d     = len_full;
                        // 33-bit sum so a huge address cannot wrap into range.
                        if (frame_end > BYTE_SPACE) begin
                            range_err_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = ST_SYNC;
                        end else if (len_full == 32'd0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    baddr_d = baddr_q + 1'b1;
                    rem_d   = rem_q - 32'd1;
                    csum_d  = csum_q + in_data;
                    if (rem_q == 32'd1) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    done_d     = (in_data == csum_q);
                    csum_err_d = (in_data != csum_q);
                    state_d    = ST_REPORT;
                end
                default: ;
            endcase
        end

        if (state_q == ST_REPORT) begin
            busy_d  = 1'b0;
            state_d = ST_SYNC;
        end

        ready_d = (state_d != ST_REPORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            hdr_cnt_q   <= '0;
            addr_q      <= 32'd0;
            len_q       <= 32'd0;
            baddr_q     <= '0;
            rem_q       <= 32'd0;
            csum_q      <= 8'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            csum_err_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            baddr_q     <= baddr_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            csum_err_q  <= csum_err_d;
            range_err_q <= range_err_d;
        end
    end

    imem_word_packer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (data_xfer),
        .lane       (baddr_q[1:0]),
        .data_in    (in_data),
        .flush      ((baddr_q[1:0] == 2'd3) || (rem_q == 32'd1)),
        .waddr      (baddr_q[BA_W-1:2]),
        .imem_ena   (imem_ena),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina)
    );

    assign in_ready  = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign csum_err  = csum_err_q;
    assign range_err = range_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_loader : randomized frames checked against a byte-level frame model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_ena;
    logic [3:0]    imem_wea;
    logic [AW-1:0] imem_addra;
    logic [31:0]   imem_dina;
    logic          busy, done, csum_err, range_err;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_WIDTH (AW),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_ena   (imem_ena),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .busy       (busy),
        .done       (done),
        .csum_err   (csum_err),
        .range_err  (range_err)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [3:0]    m;
        logic [31:0]   d;
    } wr_t;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    wr_t        w_obs;
    int         n_done = 0, n_cerr = 0, n_rerr = 0;
    int         n_vec = 0, n_err = 0;
    logic [7:0] pay [0:63];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_ena) begin
                w_obs.a = imem_addra;
                w_obs.m = imem_wea;
                w_obs.d = imem_dina;
                obs_q.push_back(w_obs);
            end else if (imem_wea != 4'd0) begin
                check_eq("wea_idle", {60'd0, imem_wea}, 64'd0);
            end
            if (done)      n_done++;
            if (csum_err)  n_cerr++;
            if (range_err) n_rerr++;
        end
    end

    // Reference: bytes grouped by destination word; returns 0 done, 1 csum_err, 2 range_err.
    function automatic int model_frame(input logic [31:0] addr, input logic [31:0] len,
                                       input logic [7:0] cs);
        wr_t         cur;
        bit          open = 1'b0;
        logic [7:0]  sum  = 8'd0;
        logic [31:0] ba;
        exp_q.delete();
        cur = '0;
        if (({1'b0, addr} + {1'b0, len}) > 33'h1_0000) return 2;
        for (int i = 0; i < int'(len); i++) begin
            ba = addr + 32'(i);
            if (!open || cur.a != ba[AW+1:2]) begin
                if (open) exp_q.push_back(cur);
                cur   = '0;
                cur.a = ba[AW+1:2];
                open  = 1'b1;
            end
            cur.m[ba[1:0]]       = 1'b1;
            cur.d[8*ba[1:0] +: 8] = pay[i];
            sum += pay[i];
        end
        if (open) exp_q.push_back(cur);
        return (sum == cs) ? 0 : 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int   waited;
        logic rdy;
        waited   = 0;
        in_valid = 1'b0;
        if (gap_max > 0) tick($urandom_range(gap_max, 0));
        in_data  = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 50);
        if (!rdy) check_eq("hs_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            do g = 8'($urandom); while (g == 8'hA5);
            send_byte(g, 1);
        end
    endtask

    task automatic run_frame(input logic [31:0] addr, input logic [31:0] len,
                             input logic [7:0] cs, input int gap);
        int st, base_w, bd, bc, br;
        base_w = obs_q.size();
        bd = n_done; bc = n_cerr; br = n_rerr;
        st = model_frame(addr, len, cs);
        send_byte(8'hA5, gap);
        check_eq("busy_set", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], gap);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gap);
        if (st != 2) begin
            for (int i = 0; i < int'(len); i++) send_byte(pay[i], gap);
            send_byte(cs, gap);
        end
        tick(4);
        check_eq("n_writes", 64'(obs_q.size() - base_w), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base_w + i < obs_q.size(); i++) begin
            check_eq("addra", 64'(obs_q[base_w+i].a), 64'(exp_q[i].a));
            check_eq("wea",   64'(obs_q[base_w+i].m), 64'(exp_q[i].m));
            check_eq("dina",  64'(obs_q[base_w+i].d), 64'(exp_q[i].d));
        end
        check_eq("done_cnt",  64'(n_done - bd), 64'(st == 0));
        check_eq("cerr_cnt",  64'(n_cerr - bc), 64'(st == 1));
        check_eq("rerr_cnt",  64'(n_rerr - br), 64'(st == 2));
        check_eq("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic load_aligned_payload();
        for (int i = 0; i < 8; i++) pay[i] = 8'h11 + 8'(i);
    endtask

    initial begin
        logic [31:0] a, l;
        logic [7:0]  cs;
        int          sel;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        tick(3);
        check_eq("rst_ready", {63'd0, in_ready}, 64'd0);
        check_eq("rst_ena",   {63'd0, imem_ena}, 64'd0);
        check_eq("rst_wea",   {60'd0, imem_wea}, 64'd0);
        check_eq("rst_stat",  {60'd0, busy, done, csum_err, range_err}, 64'd0);
        rst = 1'b0;
        tick(1);
        check_eq("ready_after_rst", {63'd0, in_ready}, 64'd1);

        load_aligned_payload();
        run_frame(32'h10, 32'd8, 8'hA4, 0);

        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        run_frame(32'h3, 32'd3, 8'h31, 0);

        load_aligned_payload();
        run_frame(32'h10, 32'd8, 8'h00, 0);

        run_frame(32'h0000_FFFC, 32'd8, 8'h00, 0);
        load_aligned_payload();
        run_frame(32'h20, 32'd8, 8'hA4, 0);

        run_frame(32'h40, 32'd0, 8'h00, 0);

        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        run_frame(32'h10, 32'd8, 8'hA4, 0);

        run_frame(32'h10, 32'd8, 8'hA4, 3);

        // Abort mid-DATA right after the first word flush has been registered.
        send_byte(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) send_byte(pay[i], 0);
        check_eq("ena_before_rst", {63'd0, imem_ena}, 64'd1);
        rst = 1'b1;
        #1;
        check_eq("ena_async_rst",  {63'd0, imem_ena}, 64'd0);
        check_eq("busy_async_rst", {63'd0, busy}, 64'd0);
        check_eq("stat_async_rst", {61'd0, done, csum_err, range_err}, 64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check_eq("ready_after_rst2", {63'd0, in_ready}, 64'd1);
        run_frame(32'h10, 32'd8, 8'hA4, 0);

        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(5, 0));
            l   = 32'($urandom_range(12, 0));
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = 32'h1_0000 - 32'($urandom_range(8, 0));
            else               a = 32'($urandom_range(65535, 0));
            cs = 8'd0;
            for (int i = 0; i < int'(l); i++) begin
                pay[i] = 8'($urandom);
                cs += pay[i];
            end
            if ($urandom_range(3, 0) == 0) cs = cs ^ 8'h5A;
            send_garbage(int'($urandom_range(2, 0)));
            run_frame(a, l, cs, int'($urandom_range(2, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
